dm_arbiter: RTL and testbench
=============================

Name: dm_arbiter

Overview:
- Two-port arbiter and sequencer in front of the byte-addressed, big-endian data memory.
- Port 0 is the CPU MEM-stage load/store port. Port 1 is the debug/loader port.
- Grants one word access at a time with round-robin fairness and drives the memory's MemRead/MemWrite strobes, address and write data.
- Returns read data and a done/err pulse to the owning requester.

Parameters:
- ADDR_W, 32, address width of requester and memory addresses.
- DATA_W, 32, word width.
- MEM_BYTES, 256, memory size in bytes; used for the bounds check.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- m0_req  input  1  port 0 access request; held until m0_done.
- m0_we  input  1  port 0 write enable (1 = store, 0 = load).
- m0_addr  input  ADDR_W  port 0 byte address.
- m0_wdata  input  DATA_W  port 0 store data.
- m0_gnt  output  1  port 0 owns the memory (ACCESS and CAPTURE states).
- m0_done  output  1  one-cycle completion pulse for port 0.
- m0_err  output  1  qualifies m0_done: access rejected.
- m0_rdata  output  DATA_W  port 0 load data; valid when m0_done=1 and m0_err=0.
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_done, m1_err, m1_rdata: identical set for port 1.
- dm_addr  output  ADDR_W  memory address.
- dm_data  output  DATA_W  memory write data.
- dm_MemRead  output  1  memory read strobe.
- dm_MemWrite  output  1  memory write strobe.
- dm_rdata  input  DATA_W  memory read data.
- busy  output  1  state is not IDLE.

Behaviour:
- Clocking and reset: single clock domain. rst_n is asynchronous active-low.
- Reset values: state=IDLE; all outputs 0 (gnt, done, err, rdata, dm_addr, dm_data, strobes, busy); last_owner=1, so port 0 wins the first tie.
- States: IDLE, ACCESS, CAPTURE.
- IDLE:
  - Eligible request: mX_req=1 and mX_done=0 in the same cycle. A requester must drop req in its done cycle; the arbiter ignores req from a port while that port's done is high.
  - One eligible port: it wins.
  - Both eligible: the port != last_owner wins.
  - On the clock edge: latch owner, we, addr and wdata; set last_owner=owner; go to ACCESS. No eligible port: stay in IDLE.
- Error check, evaluated on the latched address: err if addr[1:0]!=0 or addr > MEM_BYTES-4.
- ACCESS (1 cycle):
  - owner gnt=1; dm_addr and dm_data hold the latched values.
  - No error: dm_MemWrite=we, dm_MemRead=!we. Error: both strobes stay 0.
  - Next state: CAPTURE.
- CAPTURE (1 cycle):
  - Strobes 0; gnt and dm_addr held.
  - On the exiting edge: if read and no error, register dm_rdata into owner rdata.
  - Owner done=1 and err per the check for the next cycle. Go to IDLE.
- Output registers:
  - done/err are one-cycle pulses, asserted in the IDLE cycle after CAPTURE.
  - mX_rdata holds its last value until the next successful load to that port. Writes and errors leave it unchanged.
- Latency: request first visible in IDLE cycle T; ACCESS at T+1; CAPTURE at T+2; done at T+3. Throughput is one access per 3 cycles, or 4 cycles when the same port re-requests, since its req is ignored during its done cycle.
- Strobe rule: dm_MemRead and dm_MemWrite are never high together and never high outside ACCESS.
- Request changes: changes to req, addr or wdata after the IDLE latch edge have no effect on the in-flight access. Dropping req mid-access does not abort it.
- Reset mid-operation: all outputs clear immediately, state returns to IDLE, and the in-flight access is lost with no done pulse.
- Simultaneous events: one port's done pulse and the other port's request win in the same IDLE cycle are legal and required.

Test Plan:
- Single write then read: m0 writes 0xDEADBEEF to addr 0x10; m0 then reads 0x10.
  - Write: dm_MemWrite high exactly in cycle T+1 with dm_addr=0x10; m0_done at T+3 with err=0.
  - Read: m0_rdata=0xDEADBEEF.
- Tie after reset: m0_req and m1_req both rise in the same cycle.
  - m0 is granted first; m1 is granted in the IDLE cycle of m0's done; grants alternate while both requests stay held.
- Misaligned access: m1 reads addr 0x13.
  - No strobe asserted; m1_done=1 and m1_err=1 at T+3; m1_rdata unchanged.
- Out of range access: m0 writes addr 0xFC; then m0 writes addr 0x100.
  - 0xFC: accepted with err=0.
  - 0x100: err=1 and no dm_MemWrite pulse.
- Mid-access changes: m0 changes addr from 0x20 to 0x40 during ACCESS.
  - Memory sees only 0x20.
- Reset mid-access: rst_n low during ACCESS.
  - dm_MemRead/dm_MemWrite drop asynchronously; no done pulse; after release, the first tie goes to m0.

Source files
------------

// File: rtl/dm_arbiter.sv
// Two-port round-robin arbiter/sequencer for the big-endian data memory.
// Port 0 is the CPU MEM stage; port 1 is the debug/loader port.
module dm_arbiter #(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int MEM_BYTES = 256
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              m0_req,
   input  logic              m0_we,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   output logic              m0_gnt,
   output logic              m0_done,
   output logic              m0_err,
   output logic [DATA_W-1:0] m0_rdata,
   input  logic              m1_req,
   input  logic              m1_we,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic              m1_gnt,
   output logic              m1_done,
   output logic              m1_err,
   output logic [DATA_W-1:0] m1_rdata,
   output logic [ADDR_W-1:0] dm_addr,
   output logic [DATA_W-1:0] dm_data,
   output logic              dm_MemRead,
   output logic              dm_MemWrite,
   input  logic [DATA_W-1:0] dm_rdata,
   output logic              busy
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACCESS,
      S_CAPTURE
   } state_t;

   localparam logic [ADDR_W-1:0] MAX_A = ADDR_W'(MEM_BYTES - 4);

   state_t            state_q, state_d;
   logic              owner_q, owner_d;
   logic              last_q, last_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              done0_q, done0_d, err0_q, err0_d;
   logic              done1_q, done1_d, err1_q, err1_d;
   logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

   logic elig0, elig1, pick, err, acc;

   // A port's req is ignored while its own done pulse is high
   assign elig0 = m0_req & ~done0_q;
   assign elig1 = m1_req & ~done1_q;
   assign err   = (addr_q[1:0] != 2'b00) | (addr_q > MAX_A);

   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      last_d   = last_q;
      we_d     = we_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      done0_d  = 1'b0;
      err0_d   = 1'b0;
      done1_d  = 1'b0;
      err1_d   = 1'b0;
      rdata0_d = rdata0_q;
      rdata1_d = rdata1_q;
      pick     = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (elig0 | elig1) begin
               pick    = (elig0 & elig1) ? ~last_q : elig1;
               owner_d = pick;
               last_d  = pick;
               we_d    = pick ? m1_we : m0_we;
               addr_d  = pick ? m1_addr : m0_addr;
               wdata_d = pick ? m1_wdata : m0_wdata;
               state_d = S_ACCESS;
            end
         end
         S_ACCESS: state_d = S_CAPTURE;
         S_CAPTURE: begin
            state_d = S_IDLE;
            if (owner_q) begin
               done1_d = 1'b1;
               err1_d  = err;
               if (!we_q && !err) rdata1_d = dm_rdata;
            end else begin
               done0_d = 1'b1;
               err0_d  = err;
               if (!we_q && !err) rdata0_d = dm_rdata;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         owner_q  <= 1'b0;
         last_q   <= 1'b1;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         done0_q  <= 1'b0;
         err0_q   <= 1'b0;
         done1_q  <= 1'b0;
         err1_q   <= 1'b0;
         rdata0_q <= '0;
         rdata1_q <= '0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         last_q   <= last_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         done0_q  <= done0_d;
         err0_q   <= err0_d;
         done1_q  <= done1_d;
         err1_q   <= err1_d;
         rdata0_q <= rdata0_d;
         rdata1_q <= rdata1_d;
      end
   end

   assign busy        = (state_q != S_IDLE);
   assign acc         = (state_q == S_ACCESS) & ~err;
   assign m0_gnt      = busy & ~owner_q;
   assign m1_gnt      = busy & owner_q;
   assign dm_addr     = busy ? addr_q : '0;
   assign dm_data     = busy ? wdata_q : '0;
   assign dm_MemWrite = acc & we_q;
   assign dm_MemRead  = acc & ~we_q;
   assign m0_done     = done0_q;
   assign m0_err      = err0_q;
   assign m0_rdata    = rdata0_q;
   assign m1_done     = done1_q;
   assign m1_err      = err1_q;
   assign m1_rdata    = rdata1_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter with a small word memory model.
// Inputs change 1ns after the rising edge; outputs are checked there too.
module tb_dm_arbiter;

   logic        clk;
   logic        rst_n;
   logic        m0_req, m0_we, m1_req, m1_we;
   logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
   logic        m0_gnt, m0_done, m0_err, m1_gnt, m1_done, m1_err;
   logic [31:0] m0_rdata, m1_rdata;
   logic [31:0] dm_addr, dm_data, dm_rdata;
   logic        dm_MemRead, dm_MemWrite, busy;

   int n_chk = 0;
   int n_err = 0;

   logic [31:0] mem [0:63];

   dm_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_BYTES(256)) dut (
      .clk(clk), .rst_n(rst_n),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr),
      .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_done(m0_done),
      .m0_err(m0_err), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr),
      .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_done(m1_done),
      .m1_err(m1_err), .m1_rdata(m1_rdata),
      .dm_addr(dm_addr), .dm_data(dm_data),
      .dm_MemRead(dm_MemRead), .dm_MemWrite(dm_MemWrite),
      .dm_rdata(dm_rdata), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk)
      if (dm_MemWrite) mem[dm_addr[7:2]] <= dm_data;
   assign dm_rdata = mem[dm_addr[7:2]];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      assert (got === exp)
      else begin
         n_err++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic set0(input logic r, input logic w, input logic [31:0] a,
                       input logic [31:0] d);
      m0_req = r; m0_we = w; m0_addr = a; m0_wdata = d;
   endtask

   task automatic set1(input logic r, input logic w, input logic [31:0] a,
                       input logic [31:0] d);
      m1_req = r; m1_we = w; m1_addr = a; m1_wdata = d;
   endtask

   initial begin
      rst_n = 1'b0;
      set0(0, 0, 0, 0);
      set1(0, 0, 0, 0);
      step();
      chk("rst_busy", busy, 0);
      chk("rst_strobes", {dm_MemRead, dm_MemWrite}, 0);
      chk("rst_gnt", {m0_gnt, m1_gnt}, 0);
      chk("rst_done", {m0_done, m0_err, m1_done, m1_err}, 0);
      chk("rst_rdata0", m0_rdata, 0);
      chk("rst_dm_addr", dm_addr, 0);
      step();
      rst_n = 1'b1;
      step();

      // single write at 0x10, latency T..T+3
      set0(1, 1, 32'h10, 32'hDEADBEEF);
      chk("wr_T_busy", busy, 0);
      step();
      chk("wr_T1_we", dm_MemWrite, 1);
      chk("wr_T1_re", dm_MemRead, 0);
      chk("wr_T1_addr", dm_addr, 32'h10);
      chk("wr_T1_data", dm_data, 32'hDEADBEEF);
      chk("wr_T1_gnt", {m0_gnt, m1_gnt}, 2'b10);
      step();
      chk("wr_T2_we", dm_MemWrite, 0);
      chk("wr_T2_gnt", m0_gnt, 1);
      chk("wr_T2_done", m0_done, 0);
      step();
      chk("wr_T3_done", {m0_done, m0_err}, 2'b10);
      chk("wr_T3_busy", busy, 0);
      set0(0, 0, 0, 0);
      step();
      chk("wr_T4_done", m0_done, 0);

      // read back 0x10
      set0(1, 0, 32'h10, 32'h0);
      step();
      chk("rd_T1_re", {dm_MemRead, dm_MemWrite}, 2'b10);
      step();
      step();
      chk("rd_T3_done", {m0_done, m0_err}, 2'b10);
      chk("rd_T3_rdata", m0_rdata, 32'hDEADBEEF);
      set0(0, 0, 0, 0);
      step();

      // misaligned read on port 1
      set1(1, 0, 32'h13, 32'h0);
      step();
      chk("mis_T1_strobe", {dm_MemRead, dm_MemWrite}, 0);
      chk("mis_T1_gnt", {m0_gnt, m1_gnt}, 2'b01);
      step();
      step();
      chk("mis_T3_done", {m1_done, m1_err}, 2'b11);
      chk("mis_T3_rdata", m1_rdata, 0);
      set1(0, 0, 0, 0);
      step();

      // upper bound: 0xFC ok, 0x100 rejected
      set0(1, 1, 32'hFC, 32'hCAFEF00D);
      step();
      chk("fc_T1_we", dm_MemWrite, 1);
      step();
      step();
      chk("fc_T3_done", {m0_done, m0_err}, 2'b10);
      set0(0, 0, 0, 0);
      step();
      set0(1, 1, 32'h100, 32'h55555555);
      step();
      chk("oor_T1_strobe", {dm_MemRead, dm_MemWrite}, 0);
      step();
      chk("oor_T2_strobe", {dm_MemRead, dm_MemWrite}, 0);
      step();
      chk("oor_T3_done", {m0_done, m0_err}, 2'b11);
      set0(0, 0, 0, 0);
      step();
      set0(1, 0, 32'hFC, 32'h0);
      step();
      step();
      step();
      chk("fc_rd_rdata", m0_rdata, 32'hCAFEF00D);
      set0(0, 0, 0, 0);
      step();

      // request changes after latch are ignored
      set0(1, 1, 32'h20, 32'h11112222);
      step();
      set0(0, 1, 32'h40, 32'h99999999);
      #1;
      chk("mid_T1_addr", dm_addr, 32'h20);
      chk("mid_T1_data", dm_data, 32'h11112222);
      chk("mid_T1_we", dm_MemWrite, 1);
      step();
      chk("mid_T2_addr", dm_addr, 32'h20);
      step();
      chk("mid_T3_done", m0_done, 1);
      set0(0, 0, 0, 0);
      step();

      // tie after reset: m0 first, then alternate
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      step();
      set0(1, 0, 32'h10, 32'h0);
      set1(1, 0, 32'h20, 32'h0);
      step();
      chk("tie_T1_gnt", {m0_gnt, m1_gnt}, 2'b10);
      chk("tie_T1_addr", dm_addr, 32'h10);
      step();
      step();
      chk("tie_T3_done0", m0_done, 1);
      chk("tie_T3_rdata0", m0_rdata, 32'hDEADBEEF);
      step();
      chk("tie_T4_gnt", {m0_gnt, m1_gnt}, 2'b01);
      chk("tie_T4_addr", dm_addr, 32'h20);
      step();
      step();
      chk("tie_T6_done1", m1_done, 1);
      chk("tie_T6_rdata1", m1_rdata, 32'h11112222);
      step();
      chk("tie_T7_gnt", {m0_gnt, m1_gnt}, 2'b10);
      step();
      step();
      chk("tie_T9_done0", m0_done, 1);
      step();
      chk("tie_T10_gnt", {m0_gnt, m1_gnt}, 2'b01);
      set0(0, 0, 0, 0);
      set1(0, 0, 0, 0);
      step();
      step();
      chk("tie_T12_done1", m1_done, 1);
      step();

      // reset during ACCESS
      set1(1, 1, 32'h30, 32'h77777777);
      step();
      chk("rma_T1_we", dm_MemWrite, 1);
      rst_n = 1'b0;
      #1;
      chk("rma_strobe", {dm_MemRead, dm_MemWrite}, 0);
      chk("rma_busy", busy, 0);
      set1(0, 0, 0, 0);
      step();
      rst_n = 1'b1;
      chk("rma_done_a", {m1_done, m1_err}, 0);
      step();
      chk("rma_done_b", m1_done, 0);
      set0(1, 0, 32'h10, 32'h0);
      set1(1, 0, 32'h20, 32'h0);
      step();
      chk("rma_tie_gnt", {m0_gnt, m1_gnt}, 2'b10);
      set0(0, 0, 0, 0);
      set1(0, 0, 0, 0);
      step();
      step();
      step();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
